// File: rtl/alu_share_arbiter_if.sv
// Handshake/bus bundle between the two requesters, the shared ALU and alu_share_arbiter.
// slave = the arbiter's view; master = the environment (requesters + ALU).
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4
);
  logic [1:0]              req_i;
  logic [2*OP_WIDTH-1:0]   op_i;
  logic [2*DATA_WIDTH-1:0] a_i;
  logic [2*DATA_WIDTH-1:0] b_i;
  logic [1:0]              gnt_o;
  logic [OP_WIDTH-1:0]     alu_operation_o;
  logic [DATA_WIDTH-1:0]   alu_a_o;
  logic [DATA_WIDTH-1:0]   alu_b_o;
  logic [DATA_WIDTH-1:0]   alu_result_i;
  logic                    alu_zero_i;
  logic [1:0]              rsp_valid_o;
  logic [1:0]              rsp_ready_i;
  logic [2*DATA_WIDTH-1:0] rsp_data_o;
  logic [1:0]              rsp_zero_o;
  logic [1:0]              rsp_err_o;

  modport slave (
    input  req_i, op_i, a_i, b_i, alu_result_i, alu_zero_i, rsp_ready_i,
    output gnt_o, alu_operation_o, alu_a_o, alu_b_o, rsp_valid_o, rsp_data_o,
           rsp_zero_o, rsp_err_o
  );

  modport master (
    output req_i, op_i, a_i, b_i, alu_result_i, alu_zero_i, rsp_ready_i,
    input  gnt_o, alu_operation_o, alu_a_o, alu_b_o, rsp_valid_o, rsp_data_o,
           rsp_zero_o, rsp_err_o
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters: arbitration, issue register, response slots.
// Define ALU_SHARE_FIXED_PRIO_EN for fixed priority (requester 0 wins ties); default is round-robin.
module alu_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned OP_WIDTH   = 4
) (
  input logic               clk,
  input logic               reset,
  alu_share_arbiter_if.slave bus
);

  localparam int unsigned NREQ = 2;
  localparam logic [OP_WIDTH-1:0] INVALID_OP = '1;

  logic                  r_issue_valid;
  logic                  r_issue_id;
  logic [OP_WIDTH-1:0]   r_issue_op;
  logic [DATA_WIDTH-1:0] r_issue_a;
  logic [DATA_WIDTH-1:0] r_issue_b;

  logic [NREQ-1:0]       r_rsp_valid;
  logic [NREQ-1:0]       r_rsp_zero;
  logic [NREQ-1:0]       r_rsp_err;
  logic [DATA_WIDTH-1:0] r_rsp_data [NREQ];

  logic [NREQ-1:0]       w_elig;
  logic [NREQ-1:0]       w_gnt;
  logic                  w_gnt_id;

`ifndef ALU_SHARE_FIXED_PRIO_EN
  logic                  r_last;
`endif

  // A requester may go when it is not already in the issue stage and its slot is free or draining.
  always_comb begin
    w_elig = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      w_elig[k] = bus.req_i[k]
                & ~(r_issue_valid & (r_issue_id == 1'(k)))
                & (~r_rsp_valid[k] | bus.rsp_ready_i[k]);
    end
  end

  always_comb begin
    w_gnt = '0;
    case (w_elig)
      2'b01:   w_gnt = 2'b01;
      2'b10:   w_gnt = 2'b10;
`ifdef ALU_SHARE_FIXED_PRIO_EN
      2'b11:   w_gnt = 2'b01;
`else
      2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
`endif
      default: w_gnt = '0;
    endcase
  end

  assign w_gnt_id  = w_gnt[1];
  assign bus.gnt_o = w_gnt & {NREQ{reset}};

  // Issue stage: holds the winner's operands for one cycle while the ALU evaluates them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_issue_valid <= 1'b0;
      r_issue_id    <= 1'b0;
      r_issue_op    <= '0;
      r_issue_a     <= '0;
      r_issue_b     <= '0;
    end else begin
      r_issue_valid <= |w_gnt;
      if (|w_gnt) begin
        r_issue_id <= w_gnt_id;
        r_issue_op <= w_gnt_id ? bus.op_i[2*OP_WIDTH-1:OP_WIDTH]   : bus.op_i[OP_WIDTH-1:0];
        r_issue_a  <= w_gnt_id ? bus.a_i[2*DATA_WIDTH-1:DATA_WIDTH] : bus.a_i[DATA_WIDTH-1:0];
        r_issue_b  <= w_gnt_id ? bus.b_i[2*DATA_WIDTH-1:DATA_WIDTH] : bus.b_i[DATA_WIDTH-1:0];
      end
    end
  end

`ifndef ALU_SHARE_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last <= 1'b1;
    end else if (|w_gnt) begin
      r_last <= w_gnt_id;
    end
  end
`endif

  // Response slots: a capture wins over a simultaneous drain, so valid stays high with new data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rsp_valid <= '0;
      r_rsp_zero  <= '0;
      r_rsp_err   <= '0;
      for (int k = 0; k < int'(NREQ); k++) r_rsp_data[k] <= '0;
    end else begin
      for (int k = 0; k < int'(NREQ); k++) begin
        if (r_issue_valid && (r_issue_id == 1'(k))) begin
          r_rsp_valid[k] <= 1'b1;
          r_rsp_data[k]  <= bus.alu_result_i;
          r_rsp_zero[k]  <= bus.alu_zero_i;
          r_rsp_err[k]   <= (r_issue_op == INVALID_OP);
        end else if (r_rsp_valid[k] && bus.rsp_ready_i[k]) begin
          r_rsp_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign bus.alu_operation_o = r_issue_op;
  assign bus.alu_a_o         = r_issue_a;
  assign bus.alu_b_o         = r_issue_b;
  assign bus.rsp_valid_o     = r_rsp_valid;
  assign bus.rsp_zero_o      = r_rsp_zero;
  assign bus.rsp_err_o       = r_rsp_err;
  assign bus.rsp_data_o      = {r_rsp_data[1], r_rsp_data[0]};

endmodule
